// File: rtl/fsm_out_pkg.sv
// ============================================================================
// Module : fsm_out_pkg
// Desc   : Shared types and default constants for the fsm_out datapath.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_out_pkg;

   typedef enum logic [1:0] {
      SEL_NONE    = 2'b00,
      SEL_SYNC    = 2'b01,
      SEL_HDR     = 2'b10,
      SEL_PAYLOAD = 2'b11
   } out_sel_t;

   localparam int         DATA_W_DEF    = 8;
   localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/fsm_out_fifo.sv
// ============================================================================
// Module : fsm_out_fifo
// Desc   : Synchronous FIFO with count; overflowing pushes and underflowing
//          pops are ignored. DEPTH must be a power of 2, at least 2.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_out_fifo
   import fsm_out_pkg::*;
#(
   parameter int W     = DATA_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_wdata,
   input  logic                       i_pop,
   output logic [W-1:0]               o_rdata,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_push  = i_push && !w_full;
   assign w_pop   = i_pop && !w_empty;

   // Pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fsm_out_datapath.sv
// ============================================================================
// Module : fsm_out_datapath
// Desc   : Output datapath for the hidden_fsm controller: input FIFO, payload
//          and sequence registers, registered sync/header/payload word stream
//          and sticky protocol-error flag. Optional FSM_OUT_PARITY_EN adds a
//          registered even-parity output (out_parity).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_out_datapath
   import fsm_out_pkg::*;
#(
   parameter int                DATA_W     = DATA_W_DEF,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] SYNC_WORD  = DATA_W'(SYNC_WORD_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              data_avail,
   input  logic              buf_en,
   input  logic [1:0]        out_sel,
   input  logic              out_writing,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
`ifdef FSM_OUT_PARITY_EN
   output logic              out_parity,
`endif
   output logic              proto_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] c_DEPTH = CW'(FIFO_DEPTH);

   out_sel_t          w_sel;
   logic [CW-1:0]     w_count;
   logic [DATA_W-1:0] w_head;
   logic              w_pop;
   logic              w_out_valid;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] w_next_data;
   logic              w_err_set;
   logic [DATA_W-1:0] r_payload;
   logic [DATA_W-1:0] r_seq;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_err;

   fsm_out_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (in_valid),
      .i_wdata (in_data),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   // Handshakes come from the registered count only; no empty bypass
   assign in_ready   = (w_count != c_DEPTH);
   assign data_avail = (w_count != '0);
   assign w_sel      = out_sel_t'(out_sel);
   assign w_pop      = buf_en && data_avail;

   always_comb begin
      w_word = '0;
      case (w_sel)
         SEL_SYNC:    w_word = SYNC_WORD;
         SEL_HDR:     w_word = r_seq;
         SEL_PAYLOAD: w_word = r_payload;
         default:     w_word = '0;
      endcase
   end

   assign w_out_valid = out_writing && (w_sel != SEL_NONE);
   assign w_next_data = w_out_valid ? w_word : '0;
   assign w_err_set   = (out_writing && (w_sel == SEL_NONE)) ||
                        (buf_en && out_writing) ||
                        (buf_en && !data_avail);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_payload   <= '0;
         r_seq       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_pop) r_payload <= w_head;
         if (out_writing && (w_sel == SEL_HDR)) r_seq <= r_seq + 1'b1;
         r_out_valid <= w_out_valid;
         r_out_data  <= w_next_data;
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign proto_err = r_err;

`ifdef FSM_OUT_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_parity <= 1'b0;
      else        r_parity <= ^w_next_data;
   end

   assign out_parity = r_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_out_datapath.sv
// ============================================================================
// Module : tb_fsm_out_datapath
// Desc   : Directed self-checking bench for fsm_out_datapath.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_out_datapath;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       data_avail;
   logic       buf_en;
   logic [1:0] out_sel;
   logic       out_writing;
   logic       out_valid;
   logic [7:0] out_data;
   logic       proto_err;
`ifdef FSM_OUT_PARITY_EN
   logic       out_parity;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fsm_out_datapath dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .data_avail  (data_avail),
      .buf_en      (buf_en),
      .out_sel     (out_sel),
      .out_writing (out_writing),
      .out_valid   (out_valid),
      .out_data    (out_data),
`ifdef FSM_OUT_PARITY_EN
      .out_parity  (out_parity),
`endif
      .proto_err   (proto_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] sel, input logic be);
      out_writing = we;
      out_sel     = sel;
      buf_en      = be;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      drive(1'b0, 2'b00, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic push(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) tick();
      n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_vec++; if (data_avail !== 1'b0) begin n_err++; $display("FAIL reset_data_avail got=%b exp=0", data_avail); end
      n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_data !== 8'h00)  begin n_err++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      n_vec++; if (proto_err !== 1'b0)  begin n_err++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
   endtask

   task automatic test_fifo_fill();
      logic [7:0] exp_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      push(8'h11);
      n_vec++; if (data_avail !== 1'b1) begin n_err++; $display("FAIL fill_avail_after_first got=%b exp=1", data_avail); end
      n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL fill_ready_after_first got=%b exp=1", in_ready); end
      push(8'h22);
      push(8'h33);
      n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL fill_ready_after_third got=%b exp=1", in_ready); end
      push(8'h44);
      n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL fill_ready_full got=%b exp=0", in_ready); end
      push(8'h55);
      n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL fill_ready_after_reject got=%b exp=0", in_ready); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 2'b00, 1'b1);
         tick();
         drive(1'b1, 2'b11, 1'b0);
         tick();
         drive(1'b0, 2'b00, 1'b0);
         n_vec++;
         if (out_data !== exp_words[i] || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_drain_%0d got=%h/%b exp=%h/1", i, out_data, out_valid, exp_words[i]);
         end
      end
      n_vec++; if (data_avail !== 1'b0) begin n_err++; $display("FAIL fill_empty_after_drain got=%b exp=0", data_avail); end
      n_vec++; if (proto_err !== 1'b0)  begin n_err++; $display("FAIL fill_no_err got=%b exp=0", proto_err); end
   endtask

   task automatic test_fsm_sequence();
      logic [7:0] exp_seq [2] = '{8'h00, 8'h01};
      logic [7:0] exp_pay [2] = '{8'h00, 8'h11};
      do_reset();
      push(8'h11);
      push(8'h22);
      for (int p = 0; p < 2; p++) begin
         drive(1'b1, 2'b10, 1'b0);
         tick();
         n_vec++; if (out_valid !== 1'b1 || out_data !== exp_seq[p]) begin n_err++; $display("FAIL seq_pass%0d_hdr got=%h/%b exp=%h/1", p, out_data, out_valid, exp_seq[p]); end
         drive(1'b1, 2'b11, 1'b0);
         tick();
         n_vec++; if (out_valid !== 1'b1 || out_data !== exp_pay[p]) begin n_err++; $display("FAIL seq_pass%0d_payload got=%h/%b exp=%h/1", p, out_data, out_valid, exp_pay[p]); end
         drive(1'b0, 2'b00, 1'b1);
         tick();
         n_vec++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_err++; $display("FAIL seq_pass%0d_idle got=%h/%b exp=00/0", p, out_data, out_valid); end
         drive(1'b1, 2'b01, 1'b0);
         tick();
         n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_err++; $display("FAIL seq_pass%0d_sync got=%h/%b exp=a5/1", p, out_data, out_valid); end
      end
      drive(1'b0, 2'b00, 1'b0);
      tick();
      n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL seq_no_err got=%b exp=0", proto_err); end
   endtask

   task automatic test_underrun();
      // FIFO is empty after the previous scenario; payload holds 8'h22
      drive(1'b0, 2'b00, 1'b1);
      tick();
      n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL underrun_err got=%b exp=1", proto_err); end
      drive(1'b1, 2'b11, 1'b0);
      tick();
      n_vec++; if (out_data !== 8'h22) begin n_err++; $display("FAIL underrun_payload_held got=%h exp=22", out_data); end
      drive(1'b0, 2'b00, 1'b0);
      repeat (3) tick();
      n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL underrun_err_sticky got=%b exp=1", proto_err); end
   endtask

   task automatic test_illegal_combo();
      do_reset();
      drive(1'b1, 2'b00, 1'b0);
      tick();
      drive(1'b0, 2'b00, 1'b0);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL illegal_sel_valid got=%b exp=0", out_valid); end
      n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL illegal_sel_err got=%b exp=1", proto_err); end
      do_reset();
      push(8'h5A);
      drive(1'b1, 2'b01, 1'b1);
      tick();
      drive(1'b0, 2'b00, 1'b0);
      n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL buf_en_with_write_err got=%b exp=1", proto_err); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      push(8'h01);
      push(8'h02);
      push(8'h03);
      drive(1'b1, 2'b00, 1'b0);
      tick();
      drive(1'b1, 2'b01, 1'b0);
      tick();
      n_vec++; if (out_valid !== 1'b1 || proto_err !== 1'b1) begin n_err++; $display("FAIL midrst_pre got=%b/%b exp=1/1", out_valid, proto_err); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_data !== 8'h00)  begin n_err++; $display("FAIL midrst_out_data got=%h exp=00", out_data); end
      n_vec++; if (proto_err !== 1'b0)  begin n_err++; $display("FAIL midrst_proto_err got=%b exp=0", proto_err); end
      n_vec++; if (data_avail !== 1'b0) begin n_err++; $display("FAIL midrst_data_avail got=%b exp=0", data_avail); end
      n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      drive(1'b0, 2'b00, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      n_vec++; if (data_avail !== 1'b0) begin n_err++; $display("FAIL midrst_stays_empty got=%b exp=0", data_avail); end
   endtask

   task automatic test_seq_wrap();
      logic [7:0] exp_s;
      do_reset();
      for (int i = 0; i < 257; i++) begin
         drive(1'b1, 2'b10, 1'b0);
         tick();
         exp_s = 8'(i);
         n_vec++; if (out_data !== exp_s) begin n_err++; $display("FAIL seq_wrap_%0d got=%h exp=%h", i, out_data, exp_s); end
      end
      drive(1'b0, 2'b00, 1'b0);
      tick();
   endtask

`ifdef FSM_OUT_PARITY_EN
   task automatic test_parity();
      do_reset();
      n_vec++; if (out_parity !== 1'b0) begin n_err++; $display("FAIL parity_reset got=%b exp=0", out_parity); end
      drive(1'b1, 2'b01, 1'b0);
      tick();
      n_vec++; if (out_data !== 8'hA5 || out_parity !== 1'b0) begin n_err++; $display("FAIL parity_a5 got=%h/%b exp=a5/0", out_data, out_parity); end
      drive(1'b0, 2'b00, 1'b0);
      push(8'h07);
      drive(1'b0, 2'b00, 1'b1);
      tick();
      drive(1'b1, 2'b11, 1'b0);
      tick();
      n_vec++; if (out_data !== 8'h07 || out_parity !== 1'b1) begin n_err++; $display("FAIL parity_07 got=%h/%b exp=07/1", out_data, out_parity); end
      drive(1'b0, 2'b00, 1'b0);
      tick();
      n_vec++; if (out_parity !== 1'b0) begin n_err++; $display("FAIL parity_idle got=%b exp=0", out_parity); end
   endtask
`endif

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      drive(1'b0, 2'b00, 1'b0);
      test_reset();
      test_fifo_fill();
      test_fsm_sequence();
      test_underrun();
      test_illegal_combo();
      test_reset_midstream();
      test_seq_wrap();
`ifdef FSM_OUT_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
